sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
- Serial frame transmitter for the single-wire bit-stream interface used by the team's serial pattern detectors.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits one frame on a 1-bit serial line: sync header 1,0,1, then the payload MSB-first, then GAP_BITS trailing zeros.
- Advances one bit per bit_tick strobe, so the bit rate is set by an external divider.

Parameters:
- DATA_W, 8, payload width in bits; minimum 1.
- GAP_BITS, 2, zero bits appended after the payload; minimum 2, so downstream detector FSMs fall back to their idle state between frames.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- bit_tick  input  1  bit-rate strobe; one bit advance per cycle where it is high.
- din  input  DATA_W  payload word; sampled only on handshake.
- din_valid  input  1  upstream has a payload word.
- din_ready  output  1  block can accept a word; high exactly when the FSM is in IDLE.
- x_out  output  1  serial line; registered; idle level 0.
- tx_busy  output  1  high whenever the FSM is not in IDLE.
- frame_done  output  1  one-cycle pulse on the cycle the FSM returns to IDLE after a complete frame.

Behaviour:
- Reset state: FSM IDLE, x_out=0, frame_done=0, tx_busy=0, din_ready=1, shift register and bit counter cleared.
- Reset asserted mid-frame: frame is aborted immediately, x_out=0, no frame_done.
- Frame length L = 3 + DATA_W + GAP_BITS bits.
- Bit sequence: 1, 0, 1, din[DATA_W-1] ... din[0], then GAP_BITS zeros.
- FSM states and transitions:
  - IDLE -> SYNC: on din_valid & din_ready, latch din into the shift register and clear the bit counter.
  - SYNC -> DATA: after 3 ticks.
  - DATA -> GAP: after DATA_W ticks.
  - GAP -> IDLE: after GAP_BITS ticks plus one final tick.
- Handshake and ticks:
  - In IDLE, bit_tick is ignored and x_out holds 0.
  - din_valid while busy is not accepted; din_ready=0, and upstream must hold din/din_valid.
- Tick timing:
  - Accept plus bit_tick in the same cycle: only the accept takes effect. Bit 0 is driven on the first bit_tick strictly after the accept cycle.
  - Tick k (k = 1..L) after acceptance: x_out <= sequence bit k-1, registered on that edge. x_out holds between ticks.
  - Tick L+1: FSM -> IDLE, x_out <= 0, frame_done = 1 for exactly that cycle.
- Back-to-back frames:
  - din_ready is high in the cycle frame_done is high, so a word presented then is accepted on the next edge.
  - Minimum idle time between frames is therefore 1 clock, plus waiting for the next tick.
- Payload shifting:
  - Payload leaves a left-shifting register; x_out takes the register MSB on each DATA tick.
  - The shift register is not observable externally.
- Bit counter: width clog2(L+1). It saturates at no point; it is cleared on every state change.

Test Plan:
- Throughput baseline: DATA_W=8, GAP_BITS=2, bit_tick tied 1, din=0xA5 accepted at cycle 0 -> x_out over cycles 1..13 = 1,0,1,1,0,1,0,0,1,0,1,0,0. frame_done pulses at cycle 14; din_ready low cycles 1..13, high at 14.
- Bit-rate divider: bit_tick high every 4th cycle, din=0xFF -> each frame bit held exactly 4 cycles, 13 bits then frame_done. tx_busy high throughout the frame.
- Hold while busy: din_valid held high with din=0x3C while a 0x00 frame is in flight -> 0x3C accepted only on the edge after frame_done, then its frame starts. No word lost or duplicated.
- Accept/tick collision: accept and bit_tick in the same cycle -> x_out stays 0 that edge; the first 1 appears at the next tick.
- Reset mid-frame: assert rst during the DATA phase of 0x81 -> x_out=0, tx_busy=0, din_ready=1 immediately, no frame_done. A subsequent 0x81 frame is emitted complete and correct.
- Minimum gap: DATA_W=4, GAP_BITS=2, two back-to-back words 0xF, 0x0 -> stream 1,0,1,1,1,1,1,0,0 then 1,0,1,0,0,0,0,0,0. Exactly two frame_done pulses.

Source files
------------

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - serial frame transmitter: 1,0,1 header, MSB-first payload, zero gap
module sequence_generator #(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_tick,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x_out,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int FRAME_LEN = 3 + DATA_W + GAP_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        GAP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_n;
    logic              x_n;
    logic              done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            x_out      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            x_out      <= x_n;
            frame_done <= done_n;
        end
    end

    // The accept edge never consumes a tick; bit 0 goes out on the first tick after it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        x_n     = x_out;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                x_n = 1'b0;
                if (din_valid) begin
                    state_n = SYNC;
                    shreg_n = din;
                    cnt_n   = '0;
                end
            end
            SYNC: begin
                if (bit_tick) begin
                    x_n = (cnt != CNT_ONE);
                    if (cnt == SYNC_LAST) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            DATA: begin
                if (bit_tick) begin
                    x_n     = shreg[DATA_W-1];
                    shreg_n = shreg << 1;
                    if (cnt == DATA_LAST) begin
                        state_n = GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            GAP: begin
                // GAP_BITS zero bits, then one more tick to return to IDLE.
                if (bit_tick) begin
                    x_n = 1'b0;
                    if (cnt == GAP_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                x_n     = 1'b0;
            end
        endcase
    end

    assign din_ready = (state == IDLE);
    assign tx_busy   = (state != IDLE);

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - scoreboard bench for sequence_generator (8-bit and 4-bit payloads)
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       t8, v8, x8, r8, b8, f8;
    logic [7:0] d8;
    logic       t4, v4, x4, r4, b4, f4;
    logic [3:0] d4;

    always #5 clk = ~clk;

    sequence_generator #(.DATA_W(8), .GAP_BITS(2)) u_dut8 (
        .clk(clk), .rst(rst), .bit_tick(t8), .din(d8), .din_valid(v8),
        .din_ready(r8), .x_out(x8), .tx_busy(b8), .frame_done(f8)
    );

    sequence_generator #(.DATA_W(4), .GAP_BITS(2)) u_dut4 (
        .clk(clk), .rst(rst), .bit_tick(t4), .din(d4), .din_valid(v4),
        .din_ready(r4), .x_out(x4), .tx_busy(b4), .frame_done(f4)
    );

    int   checks = 0;
    int   errors = 0;
    bit   busy[2];
    logic ex[2];
    int   dones[2];
    bit   q0[$];
    bit   q1[$];
    int   fd8_cnt = 0;
    int   fd4_cnt = 0;

    always @(posedge clk) begin
        if (f8 === 1'b1) fd8_cnt <= fd8_cnt + 1;
        if (f4 === 1'b1) fd4_cnt <= fd4_cnt + 1;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input bit b);
        if (s == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // Reference frame: 1,0,1, payload MSB-first, two zeros; the tick after the last bit ends the frame.
    task automatic model(input int s, input bit tick, input bit acc,
                         input logic [7:0] d, input int w, output bit dn);
        bit b;
        dn = 1'b0;
        if (acc) begin
            push(s, 1'b1); push(s, 1'b0); push(s, 1'b1);
            for (int i = 0; i < w; i++) push(s, d[w-1-i]);
            push(s, 1'b0); push(s, 1'b0);
            busy[s] = 1'b1;
        end else if (busy[s] && tick) begin
            if ((s == 0 ? q0.size() : q1.size()) == 0) begin
                busy[s] = 1'b0;
                ex[s]   = 1'b0;
                dn      = 1'b1;
                dones[s]++;
            end else begin
                b     = (s == 0) ? q0.pop_front() : q1.pop_front();
                ex[s] = b;
            end
        end
    endtask

    task automatic step(input int s, input bit tick, input bit valid, input logic [7:0] d);
        bit a8, a4, dn8, dn4;
        t8 = (s == 0) && tick;
        v8 = (s == 0) && valid;
        d8 = d;
        t4 = (s == 1) && tick;
        v4 = (s == 1) && valid;
        d4 = d[3:0];
        a8 = v8 && !busy[0];
        a4 = v4 && !busy[1];
        @(posedge clk);
        #1;
        model(0, t8, a8, d8, 8, dn8);
        model(1, t4, a4, {4'b0, d4}, 4, dn4);
        chk("x8", x8, ex[0]);
        chk("done8", f8, dn8);
        chk("busy8", b8, busy[0]);
        chk("ready8", r8, !busy[0]);
        chk("x4", x4, ex[1]);
        chk("done4", f4, dn4);
        chk("busy4", b4, busy[1]);
        chk("ready4", r4, !busy[1]);
    endtask

    task automatic drain(input int s, input int period);
        int n = 0;
        while (busy[s] && n < 400) begin
            step(s, (n % period) == period - 1, 1'b0, 8'h00);
            n++;
        end
        chk("drain_idle", (s == 0) ? b8 : b4, 1'b0);
    endtask

    // Holds din_valid with the next word through the current frame; it is taken after frame_done.
    task automatic hold_next(input int s, input logic [7:0] nxt);
        int base = dones[s];
        int n    = 0;
        while (dones[s] == base && n < 400) begin
            step(s, 1'b1, 1'b1, nxt);
            n++;
        end
        chk("hold_done_seen", (s == 0) ? r8 : r4, 1'b1);
        step(s, 1'b1, 1'b1, nxt);
        chk("hold_accepted", (s == 0) ? b8 : b4, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        t8 = 0; v8 = 0; d8 = '0;
        t4 = 0; v4 = 0; d4 = '0;
        busy[0] = 0; busy[1] = 0; ex[0] = 0; ex[1] = 0; dones[0] = 0; dones[1] = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_x8", x8, 1'b0);
        chk("rst_busy8", b8, 1'b0);
        chk("rst_ready8", r8, 1'b1);
        chk("rst_done8", f8, 1'b0);
        chk("rst_x4", x4, 1'b0);
        chk("rst_ready4", r4, 1'b1);
        rst = 1'b0;

        // Baseline at full rate; accept cycle also carries a tick, which must be ignored.
        step(0, 1'b1, 1'b1, 8'hA5);
        chk("collide_x", x8, 1'b0);
        drain(0, 1);
        step(0, 1'b0, 1'b0, 8'h00);

        // Tick every 4th cycle: each bit held 4 cycles.
        step(0, 1'b0, 1'b1, 8'hFF);
        drain(0, 4);
        step(0, 1'b0, 1'b0, 8'h00);

        // Word presented while busy waits for the frame_done cycle.
        step(0, 1'b1, 1'b1, 8'h00);
        hold_next(0, 8'h3C);
        drain(0, 1);

        // Reset asserted during the DATA phase.
        step(0, 1'b1, 1'b1, 8'h81);
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_x", x8, 1'b0);
        chk("mid_rst_busy", b8, 1'b0);
        chk("mid_rst_ready", r8, 1'b1);
        chk("mid_rst_done", f8, 1'b0);
        q0.delete();
        busy[0] = 1'b0;
        ex[0]   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 1'b1, 1'b1, 8'h81);
        drain(0, 1);
        step(0, 1'b1, 1'b0, 8'h00);

        // 4-bit instance: back-to-back 0xF then 0x0 with minimum gap.
        step(1, 1'b1, 1'b1, 8'h0F);
        hold_next(1, 8'h00);
        drain(1, 1);
        step(1, 1'b1, 1'b0, 8'h00);
        step(1, 1'b1, 1'b0, 8'h00);

        chk_int("frames8", fd8_cnt, dones[0]);
        chk_int("frames8_abs", fd8_cnt, 5);
        chk_int("frames4", fd4_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
